// File: rtl/cart_mapper.sv
// rtl/cart_mapper.sv - cartridge ROM store and bank-switch mapper for the 2600 core
//
// Purpose:
//   Holds the cartridge image, which is written through the loader path. It
//   serves 6502 reads in $1000-$1FFF with a registered data output. The
//   mapper supports the 2K/4K, F8, F6 and F4 bank schemes. The CPU is held in
//   reset while an image loads, and for RESET_HOLD cycles after that.
//   Optional feature macro: CART_SUPERCHIP_EN adds 128 bytes of cart RAM
//   (write window $1000-$107F, read window $1080-$10FF).
//
// Ports:
//   clk_i      CPU clock
//   nreset     asynchronous active-low reset
//   ctrl_wr    strobe, ctrl_data valid ([0] load, [2:1] scheme, [3] 2K mirror)
//   load_wr    strobe, load_addr/load_data valid (honoured only while loading)
//   cpu_en     CPU bus cycle enable
//   cpu_addr   CPU address A12..A0
//   cpu_wdata  CPU write data (cart RAM only)
//   rom_dout   registered cart data to the CPU
//   cpu_reset  1 = hold 6502 in reset
//   bank       current bank index
module cart_mapper #(
  parameter int ADDR_BITS      = 15,
  parameter int DEFAULT_SCHEME = 0,
  parameter int RESET_HOLD     = 64
) (
  input  logic                 clk_i,
  input  logic                 nreset,
  input  logic                 ctrl_wr,
  input  logic [7:0]           ctrl_data,
  input  logic                 load_wr,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  input  logic                 cpu_en,
  input  logic [12:0]          cpu_addr,
  input  logic [7:0]           cpu_wdata,
  output logic [7:0]           rom_dout,
  output logic                 cpu_reset,
  output logic [2:0]           bank
);

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_LOAD} state_t;

  localparam int CNT_W = $clog2(RESET_HOLD + 1);

  // Power-on bank is the top bank of the scheme, where the reset vector lives.
  function automatic logic [2:0] last_bank(input logic [1:0] scheme);
    case (scheme)
      2'd0:    last_bank = 3'd0;
      2'd1:    last_bank = 3'd1;
      2'd2:    last_bank = 3'd3;
      default: last_bank = 3'd7;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       scheme_q, scheme_d;
  logic             mirror_q, mirror_d;
  logic [2:0]       bank_q, bank_d;
  logic [7:0]       rom_dout_q, rom_dout_d;
  logic             cpu_reset_q, cpu_reset_d;

  logic [7:0]           store [0:(1<<ADDR_BITS)-1];
  logic                 cart_acc;
  logic [11:0]          hot;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;

  assign cart_acc = cpu_en & cpu_addr[12];
  assign hot      = cpu_addr[11:0];
  // The size cast drops high bank bits when the store is smaller than 32 KB.
  // As a result, bank numbers beyond the image wrap.
  assign rd_addr  = ADDR_BITS'({bank_q, cpu_addr[11] & ~mirror_q, cpu_addr[10:0]});

`ifdef CART_SUPERCHIP_EN
  logic [7:0] ram [0:127];
  logic       ram_wr_win;
  logic       ram_rd_win;

  assign ram_wr_win = cpu_addr[11:7] == 5'b00000;
  assign ram_rd_win = cpu_addr[11:7] == 5'b00001;
  assign rd_data    = ram_rd_win ? ram[cpu_addr[6:0]] : store[rd_addr];

  always_ff @(posedge clk_i) begin
    if (cart_acc && ram_wr_win && state_q != ST_LOAD) begin
      ram[cpu_addr[6:0]] <= cpu_wdata;
    end
  end

  logic unused_bits;
  assign unused_bits = ^ctrl_data[7:4];
`else
  assign rd_data = store[rd_addr];

  logic unused_bits;
  assign unused_bits = ^{ctrl_data[7:4], cpu_wdata};
`endif

  always_ff @(posedge clk_i) begin
    if (load_wr && state_q == ST_LOAD) begin
      store[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scheme_d   = scheme_q;
    mirror_d   = mirror_q;
    bank_d     = bank_q;
    rom_dout_d = rom_dout_q;

    // The CPU is in reset during LOAD, so the output keeps its last value.
    if (cart_acc && state_q != ST_LOAD) begin
      rom_dout_d = rd_data;
    end

    case (state_q)
      ST_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RESET_HOLD - 1)) begin
          state_d = ST_RUN;
        end
        if (ctrl_wr && ctrl_data[0]) begin
          state_d  = ST_LOAD;
          scheme_d = ctrl_data[2:1];
          mirror_d = ctrl_data[3];
        end
      end
      ST_RUN: begin
        // The cart has no R/W line, so reads and writes both switch banks.
        if (cart_acc) begin
          case (scheme_q)
            2'd1: begin
              if (hot == 12'hFF8) bank_d = 3'd0;
              if (hot == 12'hFF9) bank_d = 3'd1;
            end
            2'd2: begin
              if (hot >= 12'hFF6 && hot <= 12'hFF9) bank_d = 3'(hot - 12'hFF6);
            end
            2'd3: begin
              if (hot >= 12'hFF4 && hot <= 12'hFFB) bank_d = 3'(hot - 12'hFF4);
            end
            default: ;
          endcase
        end
        if (ctrl_wr && ctrl_data[0]) begin
          state_d  = ST_LOAD;
          scheme_d = ctrl_data[2:1];
          mirror_d = ctrl_data[3];
        end
      end
      default: begin
        if (ctrl_wr) begin
          if (ctrl_data[0]) begin
            scheme_d = ctrl_data[2:1];
            mirror_d = ctrl_data[3];
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            bank_d  = last_bank(scheme_q);
          end
        end
      end
    endcase

    cpu_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      scheme_q    <= 2'(DEFAULT_SCHEME);
      mirror_q    <= 1'b0;
      bank_q      <= last_bank(2'(DEFAULT_SCHEME));
      rom_dout_q  <= 8'h00;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scheme_q    <= scheme_d;
      mirror_q    <= mirror_d;
      bank_q      <= bank_d;
      rom_dout_q  <= rom_dout_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign rom_dout  = rom_dout_q;
  assign cpu_reset = cpu_reset_q;
  assign bank      = bank_q;

endmodule

// File: tb/tb_cart_mapper.sv
// tb/tb_cart_mapper.sv - self-checking bench for cart_mapper
module tb_cart_mapper;

  logic        clk_i = 1'b0;
  logic        nreset = 1'b0;
  logic        ctrl_wr = 1'b0;
  logic [7:0]  ctrl_data = 8'h00;
  logic        load_wr = 1'b0;
  logic [14:0] load_addr = '0;
  logic [7:0]  load_data = 8'h00;
  logic        cpu_en = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  rom_dout;
  logic        cpu_reset;
  logic [2:0]  bank;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        en;
    logic [12:0] addr;
    logic [7:0]  dout;
    logic [2:0]  bank;
  } vec_t;

  vec_t vecs [10];

  cart_mapper #(.ADDR_BITS(15), .DEFAULT_SCHEME(0), .RESET_HOLD(64)) dut (
    .clk_i(clk_i), .nreset(nreset), .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data),
    .load_wr(load_wr), .load_addr(load_addr), .load_data(load_data),
    .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .rom_dout(rom_dout), .cpu_reset(cpu_reset), .bank(bank)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ctrl(input logic [7:0] v);
    ctrl_wr = 1'b1; ctrl_data = v;
    tick();
    ctrl_wr = 1'b0;
  endtask

  task automatic load_byte(input int a, input logic [7:0] d);
    load_wr = 1'b1; load_addr = 15'(a); load_data = d;
    tick();
    load_wr = 1'b0;
  endtask

  task automatic access(input logic [12:0] a);
    cpu_en = 1'b1; cpu_addr = a;
    tick();
    cpu_en = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (cpu_reset && n < 200) begin
      tick();
      n++;
    end
    check(name, cpu_reset, 0);
  endtask

  initial begin
    int hold;
    logic [7:0] d1000;

    // F8 walk starting in bank 1, image store[i] = i[7:0] ^ i[12:8]
    vecs[0] = '{1'b1, 13'h1000, 8'h10, 3'd1};
    vecs[1] = '{1'b1, 13'h1123, 8'h32, 3'd1};
    vecs[2] = '{1'b1, 13'h1FF8, 8'hE7, 3'd0};  // data from pre-switch bank 1
    vecs[3] = '{1'b1, 13'h1000, 8'h00, 3'd0};
    vecs[4] = '{1'b1, 13'h1FF9, 8'hF6, 3'd1};  // data from bank 0
    vecs[5] = '{1'b1, 13'h1FF7, 8'hE8, 3'd1};  // not a hotspot
    vecs[6] = '{1'b1, 13'h0FF8, 8'hE8, 3'd1};  // A12=0: hold, no switch
    vecs[7] = '{1'b1, 13'h1FF8, 8'hE7, 3'd0};
    vecs[8] = '{1'b0, 13'h1FF9, 8'hE7, 3'd0};  // cpu_en=0: hold, no switch
    vecs[9] = '{1'b1, 13'h1FF9, 8'hF6, 3'd1};

    // Reset state
    repeat (3) tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_bank", bank, 0);
    check("rst_dout", rom_dout, 8'h00);
    nreset = 1'b1;
    hold = 0;
    while (hold < 200) begin
      tick();
      hold++;
      if (!cpu_reset) break;
    end
    check("hold_cycles", hold, 64);

    // F8 load of 8 KB
    ctrl(8'h03);
    check("load_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 8192; i++) load_byte(i, 8'(i) ^ {3'b000, 5'(i >> 8)});
    ctrl(8'h02);
    check("f8_bank_after_load", bank, 1);
    wait_run("f8_run");

    for (int i = 0; i < 10; i++) begin
      cpu_en = vecs[i].en; cpu_addr = vecs[i].addr;
      tick();
      cpu_en = 1'b0;
      check($sformatf("vec%0d_dout", i), rom_dout, vecs[i].dout);
      check($sformatf("vec%0d_bank", i), bank, vecs[i].bank);
    end

    // F6 with the same image
    ctrl(8'h05);
    ctrl(8'h04);
    check("f6_bank_after_load", bank, 3);
    wait_run("f6_run");
    access(13'h1FF7); check("f6_ff7_bank", bank, 1);
    access(13'h1123); check("f6_b1_dout", rom_dout, 8'h32);
    access(13'h1FF9); check("f6_ff9_bank", bank, 3);
    access(13'h1FF6); check("f6_ff6_bank", bank, 0);
    access(13'h1005); check("f6_b0_dout", rom_dout, 8'h05);

    // F4, with a re-latch inside LOAD; reads during LOAD hold rom_dout
    ctrl(8'h03);
    access(13'h1123);
    check("load_dout_hold", rom_dout, 8'h05);
    ctrl(8'h07);
    ctrl(8'h06);
    check("f4_bank_after_load", bank, 7);
    wait_run("f4_run");
    access(13'h1FFB); check("f4_ffb_bank", bank, 7);
    access(13'h1FF4); check("f4_ff4_bank", bank, 0);
    access(13'h1FF3); check("f4_ff3_bank", bank, 0);
    access(13'h1FFC); check("f4_ffc_bank", bank, 0);
    access(13'h1FF5); check("f4_ff5_bank", bank, 1);
    access(13'h1FF3); check("f4_ff3b_bank", bank, 1);
    access(13'h1001); check("f4_b1_dout", rom_dout, 8'h11);

    // 4K with 2K mirror; last byte written together with the end-of-load ctrl
    ctrl(8'h09);
    for (int i = 0; i < 2047; i++) load_byte(i, 8'(i) ^ 8'hA5);
    load_wr = 1'b1; load_addr = 15'h07FF; load_data = 8'hFF ^ 8'hA5;
    ctrl_wr = 1'b1; ctrl_data = 8'h08;
    tick();
    load_wr = 1'b0; ctrl_wr = 1'b0;
    check("m_bank_after_load", bank, 0);
    wait_run("m_run");
    access(13'h1000); check("m_1000", rom_dout, 8'hA5);
    d1000 = rom_dout;
    access(13'h1800); check("m_1800_eq_1000", rom_dout, d1000);
    access(13'h1805); check("m_1805", rom_dout, 8'hA0);
    access(13'h1FF8); check("m_1ff8_dout", rom_dout, 8'h5D);
    check("m_1ff8_bank", bank, 0);
    access(13'h1FFF); check("m_last_byte", rom_dout, 8'h5A);
    load_byte(16'h0010, 8'h00);
    access(13'h1010); check("m_run_load_ignored", rom_dout, 8'hB5);

`ifdef CART_SUPERCHIP_EN
    cpu_wdata = 8'hA5;
    access(13'h1005);
    cpu_wdata = 8'h00;
    access(13'h1085); check("sc_ram_read", rom_dout, 8'hA5);
`else
    cpu_wdata = 8'hA5;
    access(13'h1005);
    cpu_wdata = 8'h00;
    access(13'h1085); check("no_sc_rom_read", rom_dout, 8'h20);
`endif

    // Asynchronous reset while running, after F6 bank has been changed
    ctrl(8'h05);
    ctrl(8'h04);
    wait_run("f6b_run");
    access(13'h1FF8);
    check("pre_rst_bank", bank, 2);
    #2;
    nreset = 1'b0;
    #1;
    check("arst_cpu_reset", cpu_reset, 1);
    check("arst_bank", bank, 0);
    check("arst_dout", rom_dout, 8'h00);
    tick();
    nreset = 1'b1;
    wait_run("final_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
